// File: rtl/ysyx_23060136_seg_pkg.sv
// Shared types for elastic pipeline segments: perf counter type,
// saturating increment helper and packed stage bundles.
package ysyx_23060136_seg_pkg;

  typedef logic [31:0] perf_cnt_t;

  localparam perf_cnt_t PERF_MAX = '1;

  localparam logic [63:0] PC_RST   = 64'h0000_0000_8000_0000;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        commit;
  } exu2seg_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } ifu2idu_t;

  function automatic perf_cnt_t sat_inc(input perf_cnt_t v);
    return (v == PERF_MAX) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ysyx_23060136_wrap_ptr.sv
// Buffer index with increment, clear and explicit wrap at DEPTH-1,
// so DEPTH need not be a power of two.
module ysyx_23060136_wrap_ptr
  import ysyx_23060136_seg_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_inc,
  input  logic          i_clr,
  output logic [AW-1:0] o_ptr
);

  logic [AW-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + AW'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/ysyx_23060136_elastic_seg.sv
// DEPTH-entry valid/ready pipeline segment with flush and bubble payload.
// Optional perf counters when YSYX_23060136_SEG_PERF_EN is defined.
module ysyx_23060136_elastic_seg
  import ysyx_23060136_seg_pkg::*;
#(
  parameter int                WIDTH    = 64 + 32 + 1,
  parameter int                DEPTH    = 2,
  parameter logic [WIDTH-1:0]  RST_DATA = '0,
  parameter int                CW       = $clog2(DEPTH + 1),
  parameter int                AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
`ifdef YSYX_23060136_SEG_PERF_EN
  ,
  output logic [31:0]      perf_stall,
  output logic [31:0]      perf_flush
`endif
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic [AW-1:0]    w_rd_ptr;
  logic [AW-1:0]    w_wr_ptr;
  logic             w_push;
  logic             w_pop;

  // Ready depends on registered occupancy only, never on out_ready.
  assign in_ready  = (r_count < CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign out_data  = out_valid ? mem[w_rd_ptr] : RST_DATA;
  assign count     = r_count;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  ysyx_23060136_wrap_ptr #(.DEPTH(DEPTH), .AW(AW)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_pop & ~flush),
    .i_clr (flush),
    .o_ptr (w_rd_ptr)
  );

  ysyx_23060136_wrap_ptr #(.DEPTH(DEPTH), .AW(AW)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_push & ~flush),
    .i_clr (flush),
    .o_ptr (w_wr_ptr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is left unreset; a write during flush is harmless.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem[w_wr_ptr] <= in_data;
    end
  end

`ifdef YSYX_23060136_SEG_PERF_EN
  perf_cnt_t r_perf_stall;
  perf_cnt_t r_perf_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (out_valid && !out_ready) begin
        r_perf_stall <= sat_inc(r_perf_stall);
      end
      if (flush && out_valid) begin
        r_perf_flush <= sat_inc(r_perf_flush);
      end
    end
  end

  assign perf_stall = r_perf_stall;
  assign perf_flush = r_perf_flush;
`endif

endmodule
